// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner
// Scans a 4x4 active-low matrix keypad one column at a time. It synchronises
// and debounces the row inputs, then reports one key at a time as a one-hot
// word and as a binary code.
//
// Ports
//   clk            system clock, all logic on posedge
//   rst_n          synchronous reset, active low
//   rows_n[3:0]    row sense, active low, asynchronous (2-FF synchronised)
//   cols_n[3:0]    column drive, active low, exactly one bit low
//   keypad_decode  one-hot held key (bit k = code k), 0 when no key
//   key_code[3:0]  code of the last accepted key, holds after release
//   key_valid      one-clock pulse when keypad_decode goes nonzero
//   key_held       high while a key is accepted and not yet released
module keypad_matrix_scanner #(
    parameter int SETTLE_CYCLES   = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  rows_n,
    output logic [3:0]  cols_n,
    output logic [15:0] keypad_decode,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_held
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DEB_MAX     = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] DEB_ONE     = CW'(1);
    localparam logic [7:0]    SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2
    } state_t;

    // Physical (row, col) position to key code; digits map to their own value.
    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'b00_00: code = 4'd1;
            4'b00_01: code = 4'd2;
            4'b00_10: code = 4'd3;
            4'b00_11: code = 4'd10;
            4'b01_00: code = 4'd4;
            4'b01_01: code = 4'd5;
            4'b01_10: code = 4'd6;
            4'b01_11: code = 4'd11;
            4'b10_00: code = 4'd7;
            4'b10_01: code = 4'd8;
            4'b10_10: code = 4'd9;
            4'b10_11: code = 4'd12;
            4'b11_00: code = 4'd14;
            4'b11_01: code = 4'd0;
            4'b11_10: code = 4'd15;
            4'b11_11: code = 4'd13;
            default:  code = 4'd0;
        endcase
        return code;
    endfunction

    // Active-low drive pattern for one column.
    function automatic logic [3:0] col_drive(input logic [1:0] col);
        return ~(4'b0001 << col);
    endfunction

    state_t        state_r;
    logic [1:0]    col_r;
    logic [7:0]    settle_cnt_r;
    logic [CW-1:0] deb_cnt_r;
    logic [3:0]    sync1_r;
    logic [3:0]    rows_s;
    logic [3:0]    cand_rows_r;
    logic [1:0]    cand_row_r;
    logic [1:0]    cand_col_r;

    logic [3:0]    row_low_s;
    logic          single_row_s;
    logic [1:0]    row_idx_s;
    logic [1:0]    col_next_s;
    logic [3:0]    cand_code_s;

    // Two-flop synchroniser on the asynchronous row inputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r <= 4'b1111;
            rows_s  <= 4'b1111;
        end else begin
            sync1_r <= rows_n;
            rows_s  <= sync1_r;
        end
    end

    // Row analysis: exactly-one-low detection (rejects ghosting/multi-key) and row index.
    always_comb begin
        row_low_s    = ~rows_s;
        single_row_s = (row_low_s != 4'b0000) && ((row_low_s & (row_low_s - 4'd1)) == 4'b0000);
        case (row_low_s)
            4'b0001: row_idx_s = 2'd0;
            4'b0010: row_idx_s = 2'd1;
            4'b0100: row_idx_s = 2'd2;
            4'b1000: row_idx_s = 2'd3;
            default: row_idx_s = 2'd0;
        endcase
        col_next_s  = col_r + 2'd1;
        cand_code_s = key_map(cand_row_r, cand_col_r);
    end

    // Scan / debounce / pressed state machine with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= SCAN;
            col_r         <= 2'd0;
            settle_cnt_r  <= 8'd0;
            deb_cnt_r     <= '0;
            cand_rows_r   <= 4'b1111;
            cand_row_r    <= 2'd0;
            cand_col_r    <= 2'd0;
            cols_n        <= 4'b1110;
            keypad_decode <= 16'h0000;
            key_code      <= 4'd0;
            key_valid     <= 1'b0;
            key_held      <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            case (state_r)
                SCAN: begin
                    if (settle_cnt_r == SETTLE_LAST) begin
                        settle_cnt_r <= 8'd0;
                        if (single_row_s) begin
                            // Column stays driven while the candidate is debounced.
                            cand_rows_r <= rows_s;
                            cand_row_r  <= row_idx_s;
                            cand_col_r  <= col_r;
                            deb_cnt_r   <= '0;
                            state_r     <= DEBOUNCE;
                        end else begin
                            col_r  <= col_next_s;
                            cols_n <= col_drive(col_next_s);
                        end
                    end else begin
                        settle_cnt_r <= settle_cnt_r + 8'd1;
                    end
                end
                DEBOUNCE: begin
                    if (rows_s != cand_rows_r) begin
                        // Bounce: rescan the same column from a fresh settle window.
                        deb_cnt_r    <= '0;
                        settle_cnt_r <= 8'd0;
                        state_r      <= SCAN;
                    end else if (deb_cnt_r == DEB_MAX) begin
                        keypad_decode <= 16'h0001 << cand_code_s;
                        key_code      <= cand_code_s;
                        key_valid     <= 1'b1;
                        key_held      <= 1'b1;
                        deb_cnt_r     <= '0;
                        state_r       <= PRESSED;
                    end else begin
                        deb_cnt_r <= deb_cnt_r + DEB_ONE;
                    end
                end
                PRESSED: begin
                    if (rows_s != 4'b1111) begin
                        deb_cnt_r <= '0;
                    end else if (deb_cnt_r == DEB_MAX) begin
                        keypad_decode <= 16'h0000;
                        key_held      <= 1'b0;
                        deb_cnt_r     <= '0;
                        settle_cnt_r  <= 8'd0;
                        col_r         <= col_next_s;
                        cols_n        <= col_drive(col_next_s);
                        state_r       <= SCAN;
                    end else begin
                        deb_cnt_r <= deb_cnt_r + DEB_ONE;
                    end
                end
                default: begin
                    state_r      <= SCAN;
                    col_r        <= 2'd0;
                    cols_n       <= 4'b1110;
                    settle_cnt_r <= 8'd0;
                    deb_cnt_r    <= '0;
                end
            endcase
        end
    end

endmodule
